// File: rtl/load_store_queue.sv
// In-order load/store buffer: snoops the CDB for missing operands, issues head to the MMU.
// Ready op into empty queue issues next cycle; in_ready drops when full, head waits for mmu_ready.
module load_store_queue #(
  parameter int DEPTH    = 4,
  parameter int RSV_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int INSTR_W  = 6,
  parameter int CDB_W    = RSV_ID_W + DATA_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RSV_ID_W-1:0] in_rsv_id,
  input  logic [INSTR_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0]   in_offset,
  input  logic [DATA_W-1:0]   in_base,
  input  logic                in_base_rdy,
  input  logic [RSV_ID_W-1:0] in_base_tag,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_data_rdy,
  input  logic [RSV_ID_W-1:0] in_data_tag,
  input  logic [CDB_W-1:0]    cdb,
  input  logic                cdb_valid,
  output logic [RSV_ID_W-1:0] mmu_rsv_id,
  output logic                mmu_valid,
  output logic [DATA_W-1:0]   mmu_data,
  output logic [DATA_W-1:0]   mmu_address,
  output logic [INSTR_W-1:0]  mmu_opcode,
  input  logic                mmu_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [INSTR_W-1:0]  opcode;
    logic [DATA_W-1:0]   offset;
    logic [DATA_W-1:0]   base;
    logic                base_rdy;
    logic [RSV_ID_W-1:0] base_tag;
    logic [DATA_W-1:0]   data;
    logic                data_rdy;
    logic [RSV_ID_W-1:0] data_tag;
  } entry_t;

  entry_t              q [DEPTH];
  entry_t              new_e;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W:0]      count;
  logic [RSV_ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0]   cdb_value;
  logic                enq;
  logic                deq;

  assign cdb_tag   = cdb[CDB_W-1 -: RSV_ID_W];
  assign cdb_value = cdb[DATA_W-1:0];

  assign in_ready    = (count != FULL_CNT);
  assign mmu_valid   = (count != '0) && q[head].base_rdy && q[head].data_rdy;
  assign mmu_rsv_id  = q[head].rsv_id;
  assign mmu_opcode  = q[head].opcode;
  assign mmu_data    = q[head].data;
  assign mmu_address = q[head].base + q[head].offset;

  assign enq = in_valid && in_ready;
  assign deq = mmu_valid && mmu_ready;

  // The entry being written this cycle must see the same CDB broadcast as resident entries.
  always_comb begin
    new_e          = '0;
    new_e.rsv_id   = in_rsv_id;
    new_e.opcode   = in_opcode;
    new_e.offset   = in_offset;
    new_e.base     = in_base;
    new_e.base_rdy = in_base_rdy;
    new_e.base_tag = in_base_tag;
    new_e.data     = in_data;
    new_e.data_rdy = in_data_rdy;
    new_e.data_tag = in_data_tag;
    if (cdb_valid && !in_base_rdy && (in_base_tag == cdb_tag)) begin
      new_e.base     = cdb_value;
      new_e.base_rdy = 1'b1;
    end
    if (cdb_valid && !in_data_rdy && (in_data_tag == cdb_tag)) begin
      new_e.data     = cdb_value;
      new_e.data_rdy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && !q[i].base_rdy && (q[i].base_tag == cdb_tag)) begin
          q[i].base     <= cdb_value;
          q[i].base_rdy <= 1'b1;
        end
        if (cdb_valid && !q[i].data_rdy && (q[i].data_tag == cdb_tag)) begin
          q[i].data     <= cdb_value;
          q[i].data_rdy <= 1'b1;
        end
      end
      if (enq) begin
        q[tail] <= new_e;
        tail    <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
